// File: rtl/layer3_pe.sv
// One multiply-accumulate neuron of layer3: accumulates N_IN products of din1*din2,
// then adds the bias, applies optional ReLU and 16-bit saturation, and pulses finish.
module layer3_pe #(
  parameter int N_IN  = 400,
  parameter int FRAC  = 8,
  parameter int ACC_W = 44,
  parameter int RELU  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [17:0] din1,
  input  logic [15:0] din2,
  input  logic        ena,
  input  logic [15:0] bias,
  output logic [15:0] dout,
  output logic        finish
);

  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32768);
  localparam logic [8:0]              LAST   = 9'(N_IN - 1);

  logic signed [ACC_W-1:0] acc;
  logic [8:0]              count;
  logic signed [33:0]      prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] bias_ext;
  logic signed [ACC_W-1:0] s_raw;
  logic signed [ACC_W-1:0] s_relu;
  logic [15:0]             sat_val;
  logic                    last;

  // Both operands widened to the full product width so the multiply is exact and signed.
  assign prod     = $signed({{16{din1[17]}}, din1}) * $signed({{18{din2[15]}}, din2});
  assign prod_ext = {{(ACC_W-34){prod[33]}}, prod};
  assign sum      = acc + prod_ext;
  assign shifted  = sum >>> FRAC;
  assign bias_ext = {{(ACC_W-16){bias[15]}}, bias};
  assign s_raw    = shifted + bias_ext;
  assign last     = (count == LAST);

  always_comb begin
    s_relu  = s_raw;
    sat_val = s_raw[15:0];
    if (RELU != 0 && s_raw[ACC_W-1]) s_relu = '0;
    if (s_relu > SAT_HI)      sat_val = 16'h7fff;
    else if (s_relu < SAT_LO) sat_val = 16'h8000;
    else                      sat_val = s_relu[15:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      count  <= '0;
      dout   <= '0;
      finish <= 1'b0;
    end else begin
      finish <= 1'b0;
      if (ena) begin
        if (last) begin
          dout   <= sat_val;
          finish <= 1'b1;
          acc    <= '0;
          count  <= '0;
        end else begin
          acc   <= sum;
          count <= count + 9'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_layer3_pe.sv
// Self-checking bench for layer3_pe: directed table vectors, gap/back-to-back and
// mid-vector reset sequences, and random vectors against an arithmetic reference model.
module tb_layer3_pe;

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] din1;
  logic [15:0] din2;
  logic        ena;
  logic [15:0] bias;
  logic [15:0] dout;
  logic        finish;

  layer3_pe dut (
    .clk    (clk),
    .reset  (reset),
    .din1   (din1),
    .din2   (din2),
    .ena    (ena),
    .bias   (bias),
    .dout   (dout),
    .finish (finish)
  );

  always #5 clk = ~clk;

  int     n_chk  = 0;
  int     n_fail = 0;
  longint m_sum  = 0;
  int     m_cnt  = 0;
  longint m_dout = 0;
  longint m_fin  = 0;

  typedef struct {
    int d1;
    int d2;
    int b;
    int gap;
    int exp;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs, advance the model, then compare outputs after the edge.
  task automatic cyc(input bit en, input int a, input int w, input int b);
    longint s;
    ena  = en;
    din1 = 18'(a);
    din2 = 16'(w);
    bias = 16'(b);
    @(posedge clk);
    m_fin = 0;
    if (en) begin
      m_sum += longint'(a) * longint'(w);
      m_cnt++;
      if (m_cnt == 400) begin
        s = (m_sum >>> 8) + longint'(b);
        if (s < 0) s = 0;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        m_dout = s;
        m_fin  = 1;
        m_sum  = 0;
        m_cnt  = 0;
      end
    end
    #1;
    chk("finish", longint'(finish), m_fin);
    chk("dout", longint'($signed(dout)), m_dout);
  endtask

  task automatic gaps(input int gap, input int b);
    if (gap > 0 && $urandom_range(99) < gap) begin
      for (int g = 0; g < int'($urandom_range(1, 3)); g++)
        cyc(1'b0, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128, b);
    end
  endtask

  task automatic run_vec(input int a, input int w, input int b, input int gap);
    for (int i = 0; i < 400; i++) begin
      gaps(gap, b);
      cyc(1'b1, a, w, b);
    end
  endtask

  task automatic run_rand(input int gap, input bit full);
    int a, w, b;
    for (int i = 0; i < 400; i++) begin
      b = int'($urandom_range(0, 65535)) - 32768;
      gaps(gap, b);
      if (full) begin
        a = int'($urandom_range(0, 262143)) - 131072;
        w = int'($urandom_range(0, 65535)) - 32768;
      end else begin
        a = int'($urandom_range(0, 127)) - 64;
        w = int'($urandom_range(0, 1023)) - 512;
      end
      cyc(1'b1, a, w, b);
    end
  endtask

  initial begin
    tbl[0] = '{d1: 0,   d2: 1234, b: 207, gap: 0,  exp: 207};
    tbl[1] = '{d1: 1,   d2: 256,  b: 207, gap: 0,  exp: 607};
    tbl[2] = '{d1: 256, d2: 256,  b: 207, gap: 0,  exp: 32767};
    tbl[3] = '{d1: 256, d2: -256, b: 207, gap: 0,  exp: 0};
    tbl[4] = '{d1: 1,   d2: 256,  b: 207, gap: 30, exp: 607};

    reset = 1'b0;
    ena   = 1'b0;
    din1  = '0;
    din2  = '0;
    bias  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dout", longint'($signed(dout)), 0);
    chk("reset_finish", longint'(finish), 0);
    reset = 1'b1;
    cyc(1'b0, 0, 0, 0);

    for (int i = 0; i < 5; i++) begin
      run_vec(tbl[i].d1, tbl[i].d2, tbl[i].b, tbl[i].gap);
      chk("table_finish", longint'(finish), 1);
      chk("table_dout", longint'($signed(dout)), longint'(tbl[i].exp));
      cyc(1'b0, 0, 0, 0);
    end

    // Gapped vector then back-to-back vector starting in the finish cycle.
    run_vec(1, 256, 207, 40);
    chk("b2b_first", longint'($signed(dout)), 607);
    run_vec(0, 77, 207, 0);
    chk("b2b_second", longint'($signed(dout)), 207);
    chk("b2b_finish", longint'(finish), 1);
    cyc(1'b0, 0, 0, 0);
    chk("b2b_finish_drop", longint'(finish), 0);

    // Reset mid-vector discards the partial sum.
    for (int i = 0; i < 200; i++) cyc(1'b1, 256, 256, 207);
    reset = 1'b0;
    m_sum = 0; m_cnt = 0; m_dout = 0; m_fin = 0;
    #1;
    chk("midreset_dout", longint'($signed(dout)), 0);
    for (int i = 0; i < 3; i++) begin
      ena = 1'b1;
      @(posedge clk);
      #1;
      chk("inreset_dout", longint'($signed(dout)), 0);
      chk("inreset_finish", longint'(finish), 0);
    end
    ena   = 1'b0;
    reset = 1'b1;
    cyc(1'b0, 0, 0, 0);
    run_vec(1, 256, 207, 0);
    chk("after_reset_dout", longint'($signed(dout)), 607);

    // Random vectors with changing bias and gaps.
    for (int v = 0; v < 6; v++) run_rand((v % 2) * 25, 1'b0);
    run_rand(10, 1'b1);
    run_rand(0, 1'b1);
    repeat (3) cyc(1'b0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
